// File: rtl/hash160_msg_padder_if.sv
// hash160_msg_padder_if: byte-stream intake and 512-bit block output bundle for the Hash160 padder.
interface hash160_msg_padder_if;
  logic         i_valid;
  logic [7:0]   i_data;
  logic         i_last;
  logic         i_ready;
  logic [511:0] o_block;
  logic         o_block_valid;
  logic         o_block_last;
  logic         o_block_ready;
  logic         o_err;
  modport master (output i_valid, i_data, i_last, o_block_ready,
                  input  i_ready, o_block, o_block_valid, o_block_last, o_err);
  modport slave  (input  i_valid, i_data, i_last, o_block_ready,
                  output i_ready, o_block, o_block_valid, o_block_last, o_err);
endinterface

// File: rtl/hash160_msg_padder.sv
// hash160_msg_padder: streams message bytes into 64-byte blocks and applies SHA-256 padding.
module hash160_msg_padder #(
  parameter int MAX_BLOCKS = 2,
  parameter int LEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hash160_msg_padder_if.slave  bus
);
  localparam int MAX_BYTES = 64*MAX_BLOCKS-9;
  typedef enum logic [2:0] {S_FILL, S_DRAIN, S_EMIT_DATA, S_EMIT_PAD, S_EMIT_LEN, S_EMIT_FIN} state_t;
  state_t           state_q, state_d;
  logic [6:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] total_q, total_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [7:0]       mem_q [64];
  logic [7:0]       mem_d [64];
  logic             rdy, vld, take, xfer, at_max, dat_st, len_st;
  logic [6:0]       n, mk;
  logic [63:0]      len64;
  logic [511:0]     blk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_FILL;
      ptr_q   <= '0;
      total_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      total_q <= total_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  assign rdy    = state_q == S_FILL || state_q == S_DRAIN;
  assign vld    = !rdy;
  assign take   = bus.i_valid && rdy;
  assign xfer   = vld && bus.o_block_ready;
  assign n      = ptr_q + 7'd1;
  assign at_max = total_q == LEN_W'(MAX_BYTES);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    total_d = total_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    mem_d   = mem_q;
    case (state_q)
      S_FILL: if (take) begin
        if (at_max) begin
          // The overflowing byte itself is dropped; a final byte here ends the message immediately.
          state_d = bus.i_last ? S_FILL : S_DRAIN;
          err_d   = bus.i_last;
          ptr_d   = '0;
          total_d = bus.i_last ? '0 : total_q;
        end else begin
          mem_d[ptr_q[5:0]] = bus.i_data;
          ptr_d   = n;
          total_d = total_q + LEN_W'(1);
          pend_d  = bus.i_last && n == 7'd64;
          state_d = !bus.i_last ? (n == 7'd64 ? S_EMIT_DATA : S_FILL) :
                    n <= 7'd55  ? S_EMIT_FIN : n <= 7'd63 ? S_EMIT_PAD : S_EMIT_DATA;
        end
      end
      S_DRAIN: if (take && bus.i_last) begin
        state_d = S_FILL;
        err_d   = 1'b1;
        total_d = '0;
      end
      S_EMIT_DATA: if (xfer) begin
        state_d = pend_q ? S_EMIT_LEN : S_FILL;
        ptr_d   = '0;
      end
      S_EMIT_PAD: if (xfer) state_d = S_EMIT_LEN;
      default: if (xfer) begin
        state_d = S_FILL;
        ptr_d   = '0;
        total_d = '0;
        pend_d  = 1'b0;
      end
    endcase
  end
  assign dat_st = state_q == S_EMIT_DATA || state_q == S_EMIT_PAD || state_q == S_EMIT_FIN;
  assign len_st = state_q == S_EMIT_LEN || state_q == S_EMIT_FIN;
  assign len64  = 64'({total_q, 3'b000});
  // Marker position: after the data in PAD/FIN, byte 0 of LEN when the data exactly filled a block.
  assign mk     = (state_q == S_EMIT_PAD || state_q == S_EMIT_FIN) ? ptr_q :
                  (state_q == S_EMIT_LEN && pend_q) ? 7'd0 : 7'h7f;
  always_comb begin
    blk = '0;
    for (int i = 0; i < 64; i++)
      blk[511-8*i -: 8] = (len_st && i >= 56) ? len64[8*(63-i) +: 8] :
                          (dat_st && 7'(i) < ptr_q) ? mem_q[i] :
                          (7'(i) == mk) ? 8'h80 : 8'h00;
    bus.i_ready       = rdy;
    bus.o_block       = blk;
    bus.o_block_valid = vld;
    bus.o_block_last  = len_st;
    bus.o_err         = err_q;
  end
endmodule

// File: tb/tb_hash160_msg_padder.sv
// tb_hash160_msg_padder: directed checks of padding, block sequencing, backpressure, overflow and reset.
module tb_hash160_msg_padder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic [511:0] blk_q[$];
  bit           lst_q[$];
  hash160_msg_padder_if bus ();
  hash160_msg_padder #(.MAX_BLOCKS(2), .LEN_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n) begin
    if (bus.o_block_valid && bus.o_block_ready) begin
      blk_q.push_back(bus.o_block);
      lst_q.push_back(bus.o_block_last);
    end
    if (bus.o_err) err_cnt++;
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int len, input logic [7:0] b, input bit abc, input bit no_last);
    int w;
    for (int k = 0; k < len; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = abc ? 8'h61 + 8'(k) : b;
      bus.i_last  = !no_last && k == len-1;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.i_ready && w < 300);
      if (!bus.i_ready) begin
        chk("send_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask
  task automatic get_blk(input string tag, input logic [511:0] e, input bit el);
    int w = 0;
    while (blk_q.size() == 0 && w < 300) begin @(negedge clk); w++; end
    if (blk_q.size() == 0) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk(tag, blk_q.pop_front(), e);
      chk({tag, "_last"}, 512'(lst_q.pop_front()), 512'(el));
    end
  endtask
  task automatic idle_none(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_extra"}, 512'(blk_q.size()), 0);
    blk_q.delete();
    lst_q.delete();
  endtask
  localparam logic [511:0] ABC  = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] A64  = {64{8'ha5}};
  initial begin
    bus.i_valid = 1'b0;
    bus.i_data = 8'h00;
    bus.i_last = 1'b0;
    bus.o_block_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk", bus.o_block, 0);
    chk("rst_vld", 512'(bus.o_block_valid), 0);
    chk("rst_err", 512'(bus.o_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", 512'(bus.i_ready), 1);
    send(64, 8'ha5, 0, 0);
    chk("b64_rdy_low", 512'(bus.i_ready), 0);
    get_blk("b64_b1", A64, 0);
    get_blk("b64_b2", {8'h80, 440'd0, 64'h200}, 1);
    @(posedge clk); #1;
    chk("b64_rdy_back", 512'(bus.i_ready), 1);
    idle_none("b64");
    @(posedge clk); #1;
    send(3, 8'h00, 1, 0);
    chk("abc_latency", 512'(bus.o_block_valid), 1);
    get_blk("abc", ABC, 1);
    idle_none("abc");
    @(posedge clk); #1;
    send(55, 8'h00, 0, 0);
    get_blk("z55", {440'd0, 8'h80, 64'h1b8}, 1);
    idle_none("z55");
    @(posedge clk); #1;
    send(56, 8'h00, 0, 0);
    get_blk("z56_b1", {448'd0, 8'h80, 56'd0}, 0);
    get_blk("z56_b2", {448'd0, 64'h1c0}, 1);
    idle_none("z56");
    @(posedge clk); #1;
    bus.o_block_ready = 1'b0;
    send(3, 8'h00, 1, 0);
    begin
      bit ok = 1'b1;
      repeat (10) begin
        @(negedge clk);
        ok &= bus.o_block_valid && bus.o_block === ABC && bus.o_block_last;
      end
      chk("bp_hold", 512'(ok), 1);
    end
    @(posedge clk); #1;
    bus.o_block_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_block_ready = 1'b0;
    chk("bp_rdy_next", 512'(bus.i_ready), 1);
    chk("bp_vld_drop", 512'(bus.o_block_valid), 0);
    get_blk("bp_abc", ABC, 1);
    bus.o_block_ready = 1'b1;
    idle_none("bp");
    @(posedge clk); #1;
    send(119, 8'ha5, 0, 0);
    get_blk("m119_b1", A64, 0);
    get_blk("m119_b2", {{55{8'ha5}}, 8'h80, 64'h3b8}, 1);
    idle_none("m119");
    chk("m119_err", 512'(err_cnt), 0);
    @(posedge clk); #1;
    send(120, 8'ha5, 0, 0);
    repeat (6) @(negedge clk);
    chk("m120_err_pulse", 512'(err_cnt), 1);
    get_blk("m120_b1", A64, 0);
    idle_none("m120");
    @(posedge clk); #1;
    send(130, 8'ha5, 0, 0);
    repeat (6) @(negedge clk);
    chk("m130_drain_err", 512'(err_cnt), 2);
    get_blk("m130_b1", A64, 0);
    idle_none("m130");
    @(posedge clk); #1;
    send(30, 8'h11, 0, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_blk", bus.o_block, 0);
    chk("mid_rst_vld", 512'(bus.o_block_valid), 0);
    chk("mid_rst_last", 512'(bus.o_block_last), 0);
    chk("mid_rst_err", 512'(bus.o_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 8'h00, 1, 0);
    get_blk("post_rst_abc", ABC, 1);
    idle_none("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
